// File: rtl/result_writer_pkg.sv
// Shared definitions for result_writer: FSM state encoding and index width helper.
package result_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Counter width for an index range of n values (never narrower than one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_writer.sv
// Collects N x N result tiles in row-major tile order and writes them row by row to BRAM.
// Optional macro RESULT_WRITER_RELU_EN clamps negative elements to zero on the write path.
module result_writer
    import result_writer_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FRAC_WIDTH = 8,
    parameter int unsigned BLOCK_SIZE = 2,
    parameter int unsigned OUT_ROWS   = 64,
    parameter int unsigned OUT_COLS   = 64,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] in_data,
    output logic                                  wr_en,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [WIDTH*BLOCK_SIZE-1:0]           wr_data
);

    localparam int unsigned TILE_ROWS = OUT_ROWS / BLOCK_SIZE;
    localparam int unsigned TILE_COLS = OUT_COLS / BLOCK_SIZE;
    localparam int unsigned ROW_BITS  = WIDTH * BLOCK_SIZE;
    localparam int unsigned TR_W      = idx_width(TILE_ROWS);
    localparam int unsigned TC_W      = idx_width(TILE_COLS);
    localparam int unsigned RW        = idx_width(BLOCK_SIZE);

    if ((OUT_ROWS % BLOCK_SIZE) != 0 || (OUT_COLS % BLOCK_SIZE) != 0 || FRAC_WIDTH > WIDTH) begin : g_param_err
        $error("result_writer: invalid parameter combination");
    end

    state_t                                   state_q;
    logic [TR_W-1:0]                          tile_row_q;
    logic [TC_W-1:0]                          tile_col_q;
    logic [RW-1:0]                            row_q;
    logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]   tile_q;
    logic                                     busy_q;
    logic                                     done_q;
    logic                                     in_ready_q;
    logic                                     wr_en_q;
    logic [ADDR_WIDTH-1:0]                    wr_addr_q;
    logic [ROW_BITS-1:0]                      wr_data_q;

    logic [RW-1:0]                            nrow_d;
    logic [ROW_BITS-1:0]                      sel_row;
    logic [ROW_BITS-1:0]                      wr_data_d;
    logic [ADDR_WIDTH-1:0]                    wr_addr_d;

    // Row 0 is taken straight from in_data on the handshake so it can be written the next cycle.
    always_comb begin
        nrow_d    = (state_q == ST_WRITE) ? row_q + RW'(1) : '0;
        sel_row   = (state_q == ST_WRITE) ? tile_q[32'(nrow_d) * ROW_BITS +: ROW_BITS]
                                          : in_data[ROW_BITS-1:0];
        wr_addr_d = ADDR_WIDTH'((32'(tile_row_q) * BLOCK_SIZE + 32'(nrow_d)) * TILE_COLS
                                + 32'(tile_col_q));
    end

    for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_act
`ifdef RESULT_WRITER_RELU_EN
        assign wr_data_d[c*WIDTH +: WIDTH] = sel_row[c*WIDTH + WIDTH - 1] ? '0
                                                                          : sel_row[c*WIDTH +: WIDTH];
`else
        assign wr_data_d[c*WIDTH +: WIDTH] = sel_row[c*WIDTH +: WIDTH];
`endif
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_ACCEPT && in_valid) begin
            tile_q <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            state_q    <= ST_IDLE;
            tile_row_q <= '0;
            tile_col_q <= '0;
            row_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_ACCEPT;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        state_q    <= ST_WRITE;
                        in_ready_q <= 1'b0;
                        row_q      <= '0;
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= wr_addr_d;
                        wr_data_q  <= wr_data_d;
                    end
                end
                ST_WRITE: begin
                    if (row_q == RW'(BLOCK_SIZE - 1)) begin
                        wr_en_q   <= 1'b0;
                        wr_addr_q <= '0;
                        wr_data_q <= '0;
                        if (tile_row_q == TR_W'(TILE_ROWS - 1) && tile_col_q == TC_W'(TILE_COLS - 1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_ACCEPT;
                            in_ready_q <= 1'b1;
                            if (tile_col_q == TC_W'(TILE_COLS - 1)) begin
                                tile_col_q <= '0;
                                tile_row_q <= tile_row_q + TR_W'(1);
                            end else begin
                                tile_col_q <= tile_col_q + TC_W'(1);
                            end
                        end
                    end else begin
                        row_q     <= nrow_d;
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= wr_data_d;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    done_q     <= 1'b0;
                    tile_row_q <= '0;
                    tile_col_q <= '0;
                    row_q      <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: queue-based reference model plus directed literal checks.
module tb_result_writer;

    localparam int W     = 16;
    localparam int N     = 2;
    localparam int R     = 4;
    localparam int C     = 4;
    localparam int AW    = 12;
    localparam int TC    = C / N;
    localparam int TR    = R / N;
    localparam int TOTAL = TR * TC;

    logic              clk = 1'b0;
    logic              rst_n, clr, start, in_valid;
    logic [W*N*N-1:0]  in_data;
    logic              busy, done, in_ready, wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W*N-1:0]    wr_data;

    result_writer #(
        .WIDTH(W), .FRAC_WIDTH(8), .BLOCK_SIZE(N),
        .OUT_ROWS(R), .OUT_COLS(C), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    function automatic logic [W-1:0] act(input logic [W-1:0] v);
`ifdef RESULT_WRITER_RELU_EN
        return v[W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Reference model: a queue of pending BRAM words per accepted tile.
    bit             m_busy = 0, m_ready = 0, m_done = 0, m_wr = 0;
    logic [AW-1:0]  m_addr = '0;
    logic [W*N-1:0] m_data = '0;
    logic [W*N-1:0] m_word;
    int             k = 0;
    int             hs_edge = 0;
    logic [AW-1:0]  qa[$];
    logic [W*N-1:0] qd[$];

    always @(posedge clk) begin
        cyc++;
        if (rst_n || clr) begin
            m_busy = 0; m_ready = 0; m_done = 0; m_wr = 0;
            m_addr = '0; m_data = '0; k = 0;
            qa.delete(); qd.delete();
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_ready = 1;
            end
        end else if (m_ready) begin
            if (in_valid) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) m_word[c*W +: W] = act(in_data[(r*N+c)*W +: W]);
                    qa.push_back(AW'(((k / TC) * N + r) * TC + (k % TC)));
                    qd.push_back(m_word);
                end
                if (k == 0) hs_edge = cyc;
                k++;
                m_ready = 0;
                m_wr = 1; m_addr = qa.pop_front(); m_data = qd.pop_front();
            end
        end else if (qa.size() > 0) begin
            m_wr = 1; m_addr = qa.pop_front(); m_data = qd.pop_front();
        end else begin
            m_wr = 0; m_addr = '0; m_data = '0;
            if (k == TOTAL) begin
                m_busy = 0; m_done = 1; k = 0;
            end else begin
                m_ready = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("wr_en", 64'(wr_en), 64'(m_wr));
            if (m_wr) begin
                check("wr_addr", 64'(wr_addr), 64'(m_addr));
                check("wr_data", 64'(wr_data), 64'(m_data));
            end else begin
                check("wr_data_idle", 64'(wr_data), 64'(0));
            end
        end
    end

    logic [AW-1:0]  log_a[$];
    logic [W*N-1:0] log_d[$];
    bit             done_seen = 0;
    int             done_edge = 0, last_wr_edge = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (wr_en) begin
                log_a.push_back(wr_addr);
                log_d.push_back(wr_data);
                last_wr_edge = cyc;
            end
            if (done) begin
                done_seen = 1;
                done_edge = cyc;
            end
        end
    end

    // Stimulus policy, applied once per cycle just after the falling edge.
    int           vmode = 0, gap_left = 0;
    bit           force_en = 0, noise = 0, clr_arm = 0, rnd_ctl = 0;
    bit           start_req = 0, rst_req = 0;
    logic [W*N*N-1:0] force_val = '0;

    task automatic step();
        @(negedge clk);
        #1;
        start   = start_req; start_req = 0;
        rst_n   = rst_req;   rst_req   = 0;
        clr     = 1'b0;
        if (vmode == 0)      in_valid = 1'b1;
        else if (vmode == 1) in_valid = ($urandom_range(9) < 7);
        else                 in_valid = 1'b0;
        if (m_ready && k == 2 && gap_left > 0) begin
            in_valid = 1'b0;
            gap_left--;
        end
        in_data = {$urandom, $urandom};
        if (force_en && k == 0) in_data = force_val;
        if (noise && m_busy && $urandom_range(2) == 0) start = 1'b1;
        if (clr_arm && m_wr && m_addr == AW'(6)) begin
            clr = 1'b1;
            clr_arm = 0;
        end
        if (rnd_ctl) begin
            if ($urandom_range(199) == 0) clr = 1'b1;
            if ($urandom_range(299) == 0) rst_n = 1'b1;
            if ($urandom_range(9) == 0) start = 1'b1;
        end
    endtask

    task automatic begin_run();
        log_a.delete(); log_d.delete();
        done_seen = 0;
        start_req = 1;
    endtask

    task automatic run_matrix(input string nm);
        begin_run();
        for (int i = 0; i < 200 && !done_seen; i++) step();
        check({nm, "_done_reached"}, 64'(done_seen), 64'(1));
    endtask

    task automatic check_seq(input string nm);
        logic [AW-1:0] exp_a[8];
        exp_a = '{AW'(0), AW'(2), AW'(1), AW'(3), AW'(4), AW'(6), AW'(5), AW'(7)};
        check({nm, "_nwrites"}, 64'(log_a.size()), 64'(8));
        for (int i = 0; i < 8 && i < log_a.size(); i++)
            check($sformatf("%s_addr%0d", nm, i), 64'(log_a[i]), 64'(exp_a[i]));
    endtask

    logic [W*N-1:0] relu_w0, relu_w1;

    initial begin
        rst_n = 1'b1; clr = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        step();
        step();

        // Full matrix with in_valid held high; tile 0 is {1,2,3,4} row-major.
        vmode = 0; force_en = 1;
        force_val = {16'd4, 16'd3, 16'd2, 16'd1};
        run_matrix("A");
        check_seq("A");
        if (log_d.size() >= 2) begin
            check("A_data_addr0", 64'(log_d[0]), 64'h0000_0000_0002_0001);
            check("A_data_addr2", 64'(log_d[1]), 64'h0000_0000_0004_0003);
        end else begin
            check("A_data_count", 64'(log_d.size()), 64'(2));
        end
        // Handshake cycle is cycle 0; done must be visible in cycle 12.
        check("A_latency", 64'(done_edge - hs_edge + 1), 64'(12));
        check("A_done_after_last", 64'(done_edge - last_wr_edge), 64'(1));
        force_en = 0;
        repeat (3) step();

        // Five stalled cycles between tiles 1 and 2.
        gap_left = 5;
        run_matrix("B");
        check_seq("B");
        check("B_gap_used", 64'(gap_left), 64'(0));
        repeat (3) step();

        // Abort during the second row of tile 2, then restart.
        clr_arm = 1;
        begin_run();
        for (int i = 0; i < 100 && clr_arm; i++) step();
        check("C_clr_fired", 64'(clr_arm), 64'(0));
        repeat (10) step();
        check("C_no_done", 64'(done_seen), 64'(0));
        check("C_partial_writes", 64'(log_a.size()), 64'(6));
        check("C_idle_busy", 64'(busy), 64'(0));
        run_matrix("C2");
        check_seq("C2");
        repeat (3) step();

        // Start pulses while busy must be ignored; tile 0 exercises the activation path.
        noise = 1; force_en = 1;
        force_val = {16'h0001, 16'h8000, 16'h0100, 16'hFF00};
`ifdef RESULT_WRITER_RELU_EN
        relu_w0 = 32'h0100_0000;
        relu_w1 = 32'h0001_0000;
`else
        relu_w0 = 32'h0100_FF00;
        relu_w1 = 32'h0001_8000;
`endif
        run_matrix("D");
        check_seq("D");
        if (log_d.size() >= 2) begin
            check("D_act_addr0", 64'(log_d[0]), 64'(relu_w0));
            check("D_act_addr2", 64'(log_d[1]), 64'(relu_w1));
        end else begin
            check("D_data_count", 64'(log_d.size()), 64'(2));
        end
        noise = 0; force_en = 0;
        repeat (3) step();

        // Random traffic: sporadic valid, starts, aborts and resets.
        vmode = 1; rnd_ctl = 1; noise = 1;
        repeat (3000) step();
        vmode = 0; rnd_ctl = 0; noise = 0;
        rst_req = 1;
        step();
        step();
        run_matrix("E");
        check_seq("E");
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter WIDTH, default 16, element bit width (two's complement, fixed point).
REQ-002 Parameter FRAC_WIDTH, default 8, fractional bits; carried through unchanged.
REQ-003 Parameter BLOCK_SIZE, default 2, systolic tile dimension N (tile = N x N).
REQ-004 Parameter OUT_ROWS, default 64, result matrix rows; SHALL be a multiple of BLOCK_SIZE.
REQ-005 Parameter OUT_COLS, default 64, result matrix columns; SHALL be a multiple of BLOCK_SIZE.
REQ-006 Parameter ADDR_WIDTH, default 12, result BRAM address width.
REQ-007 clk  input  1  sole clock; all logic on the rising edge.
REQ-008 rst_n  input  1  synchronous reset, active-high (asserted = 1), sampled on the rising edge of clk.
REQ-009 clr  input  1  synchronous abort; same effect as reset on state and counters.
REQ-010 start  input  1  single-cycle pulse that begins collection of one full result matrix.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  single-cycle pulse after the last BRAM write.
REQ-013 in_valid  input  1  tile from the multiplier core is valid.
REQ-014 in_ready  output  1  block accepts a tile this cycle.
REQ-015 in_data  input  WIDTH*BLOCK_SIZE*BLOCK_SIZE  tile, row-major; element (r,c) at bit offset (r*BLOCK_SIZE+c)*WIDTH.
REQ-016 wr_en  output  1  result BRAM write enable.
REQ-017 wr_addr  output  ADDR_WIDTH  result BRAM word address.
REQ-018 wr_data  output  WIDTH*BLOCK_SIZE  one tile row; element c at bit offset c*WIDTH.

Function
REQ-019 States: IDLE, ACCEPT, WRITE, DONE.
REQ-020 IDLE -> ACCEPT on start=1; start in any other state is ignored.
REQ-021 ACCEPT: in_ready=1; on in_valid&&in_ready, capture in_data into a tile register, then -> WRITE.
REQ-022 WRITE: one wr_en=1 cycle per tile row, r = 0..BLOCK_SIZE-1, starting the cycle after the handshake; in_ready=0 throughout.
REQ-023 Tiles arrive in row-major tile-grid order: tile_col increments first and wraps at OUT_COLS/BLOCK_SIZE-1, then tile_row increments.
REQ-024 wr_addr = (tile_row*BLOCK_SIZE + r) * (OUT_COLS/BLOCK_SIZE) + tile_col.
REQ-025 After the last row of a tile: -> ACCEPT if tiles remain; -> DONE after tile (OUT_ROWS/BLOCK_SIZE-1, OUT_COLS/BLOCK_SIZE-1).
REQ-026 DONE: done=1 for exactly one cycle, counters cleared, -> IDLE.
REQ-027 Throughput: one tile per BLOCK_SIZE+1 cycles when in_valid is held high.
REQ-028 in_valid low in ACCEPT: stall indefinitely, no writes, counters hold.
REQ-029 clr or rst_n at any point, mid-tile included: next cycle state IDLE, wr_en=0, partial matrix abandoned, no done.
REQ-030 Elements written without width change; no arithmetic except REQ-034.

Reset
REQ-031 While rst_n=1: state IDLE; busy, done, in_ready, wr_en = 0; wr_addr, wr_data = 0; all counters = 0.
REQ-032 Tile register needs no reset; wr_data SHALL still read 0 while wr_en=0 after reset.

Configuration
REQ-033 Macro RESULT_WRITER_RELU_EN selects output activation.
REQ-034 Defined: each element with sign bit set is written as 0; others unchanged. Undefined: all elements pass unchanged. Latency identical in both builds.

Structure
REQ-035 Shared package holds the state encoding (IDLE, ACCEPT, WRITE, DONE) and a tile-index width helper constant.
REQ-036 No sub-module; per-element ReLU is a generate loop inside result_writer.

Verification (BLOCK_SIZE=2, OUT_ROWS=OUT_COLS=4, WIDTH=16)
REQ-037 Reset then start, four tiles with in_valid held high -> write addresses 0,2,1,3,4,6,5,7; done one cycle after address 7; 12 cycles from first handshake to done.
REQ-038 Tile 0 elements {1,2,3,4} -> addr 0 data {2,1}, addr 2 data {4,3} (upper element first in the concatenation).
REQ-039 in_valid low for 5 cycles between tiles 1 and 2 -> no wr_en, in_ready held 1, address sequence unchanged.
REQ-040 clr during second row of tile 2 -> wr_en=0 next cycle, no done, IDLE; new start restarts at address 0.
REQ-041 With RESULT_WRITER_RELU_EN, tile elements {0xFF00,0x0100,0x8000,0x0001} -> words {0x0100,0x0000} then {0x0001,0x0000}; without the macro, values pass unchanged.
REQ-042 start pulse while busy -> ignored; counters and address sequence unaffected.
